// File: rtl/dram_wait_ctrl.sv
// ----------------------------------------------------------------------------
// dram_wait_ctrl: data-memory controller with req/ack handshake and latency
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module dram_wait_ctrl #(
  parameter logic [31:0] ADDR_BASE   = 32'h1001_0000,
  parameter int          DEPTH_WORDS = 2048,
  parameter int          LATENCY     = 2
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  select,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        ack,
  output logic        err,
  output logic [31:0] rdata
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT    = 33'(DEPTH_WORDS) << 2;
  localparam logic [2:0]  CNT_INIT = 3'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [1:0]  select_q, select_d;
  logic        sign_ext_q, sign_ext_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        busy_q, busy_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [31:0]   offset;
  logic [AW-1:0] word_idx;
  logic [31:0]   rd_word;
  logic          is_half;
  logic          is_byte;
  logic          is_word;
  logic          acc_err;
  logic          commit;
  logic          mem_we;
  logic [15:0]   half_val;
  logic [7:0]    byte_val;
  logic [31:0]   load_val;
  logic [3:0]    byte_en;
  logic [31:0]   wr_lanes;

  // All access decoding works on the latched request, never on live inputs.
  assign offset   = addr_q - ADDR_BASE;
  assign word_idx = offset[AW+1:2];
  assign rd_word  = mem_q[word_idx];
  assign is_half  = (select_q == 2'b01);
  assign is_byte  = (select_q == 2'b10);
  assign is_word  = !is_half && !is_byte;
  assign acc_err  = ({1'b0, offset} >= LIMIT)
                  || (is_word && (offset[1:0] != 2'b00))
                  || (is_half && offset[0]);
  assign commit   = (state_q == WAIT) && (cnt_q == 3'd0);
  assign mem_we   = commit && we_q && !acc_err;

  always_comb begin
    half_val = offset[1] ? rd_word[31:16] : rd_word[15:0];
    case (offset[1:0])
      2'd0:    byte_val = rd_word[7:0];
      2'd1:    byte_val = rd_word[15:8];
      2'd2:    byte_val = rd_word[23:16];
      default: byte_val = rd_word[31:24];
    endcase
    case (select_q)
      2'b01: begin
        load_val = {{16{sign_ext_q & half_val[15]}}, half_val};
        byte_en  = offset[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{wdata_q[15:0]}};
      end
      2'b10: begin
        load_val = {{24{sign_ext_q & byte_val[7]}}, byte_val};
        byte_en  = 4'b0001 << offset[1:0];
        wr_lanes = {4{wdata_q[7:0]}};
      end
      default: begin
        load_val = rd_word;
        byte_en  = 4'b1111;
        wr_lanes = wdata_q;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    select_d   = select_q;
    sign_ext_d = sign_ext_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    busy_d     = 1'b0;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    rdata_d    = '0;
    case (state_q)
      WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = DONE;
          ack_d   = 1'b1;
          err_d   = acc_err;
          if (!we_q && !acc_err) begin
            rdata_d = load_val;
          end
        end else begin
          cnt_d  = cnt_q - 3'd1;
          busy_d = 1'b1;
        end
      end
      default: begin
        // DONE accepts like IDLE so held requests run at LATENCY+1 throughput.
        if (req) begin
          state_d    = WAIT;
          cnt_d      = CNT_INIT;
          busy_d     = 1'b1;
          we_d       = we;
          select_d   = select;
          sign_ext_d = sign_ext;
          addr_d     = addr;
          wdata_d    = wdata;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      select_q   <= '0;
      sign_ext_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      select_q   <= select_d;
      sign_ext_q <= sign_ext_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
    end
  end

  // Storage is never cleared; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk_in) begin
    if (reset && mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem_q[word_idx][8*b +: 8] <= wr_lanes[8*b +: 8];
        end
      end
    end
  end

  assign busy  = busy_q;
  assign ack   = ack_q;
  assign err   = err_q;
  assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_dram_wait_ctrl.sv
// ----------------------------------------------------------------------------
// tb_dram_wait_ctrl: scoreboard bench over LATENCY = 2, 3, 1 and 7 instances
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_dram_wait_ctrl;

  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int          DEPTH = 2048;
  localparam logic [31:0] LIMIT = 32'(DEPTH * 4);
  localparam logic [1:0]  W = 2'b00, H = 2'b01, B = 2'b10;

  typedef struct {
    logic        is_load;
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (lat-inst %0d): got 0x%08h expected 0x%08h", nm, inst, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 4; gi++) begin : g_inst
    localparam int LAT = (gi == 0) ? 2 : (gi == 1) ? 3 : (gi == 2) ? 1 : 7;

    logic        rst_n = 1'b0;
    logic        req   = 1'b0;
    logic        we    = 1'b0;
    logic        sx    = 1'b0;
    logic [1:0]  sel   = 2'b00;
    logic [31:0] addr  = '0;
    logic [31:0] wdata = '0;
    logic        busy, ack, err;
    logic [31:0] rdata;
    logic        fin   = 1'b0;

    exp_t       q[$];
    logic [7:0] ref_mem [int];
    int         run     = 0;
    int         acks    = 0;
    int         acc_cyc = 0;

    dram_wait_ctrl #(
      .ADDR_BASE  (BASE),
      .DEPTH_WORDS(DEPTH),
      .LATENCY    (LAT)
    ) dut (
      .clk_in  (clk),
      .reset   (rst_n),
      .req     (req),
      .we      (we),
      .select  (sel),
      .sign_ext(sx),
      .addr    (addr),
      .wdata   (wdata),
      .busy    (busy),
      .ack     (ack),
      .err     (err),
      .rdata   (rdata)
    );

    // Byte-addressed reference memory; access size n in bytes, alignment = n.
    function automatic void model(input logic w, input logic [1:0] s, input logic x,
                                  input logic [31:0] a, input logic [31:0] d,
                                  output logic e, output logic [31:0] r);
      logic [31:0] off;
      int n;
      off = a - BASE;
      n   = (s == 2'b01) ? 2 : (s == 2'b10) ? 1 : 4;
      e   = (off >= LIMIT) || ((off % n) != 0);
      r   = '0;
      if (e) return;
      for (int i = 0; i < n; i++) begin
        if (w) ref_mem[int'(off) + i] = d[8*i +: 8];
        else   r[8*i +: 8] = ref_mem[int'(off) + i];
      end
      if (!w && n < 4 && x && r[8*n-1]) begin
        for (int i = n; i < 4; i++) r[8*i +: 8] = 8'hFF;
      end
    endfunction

    task automatic wait_idle();
      int n = 0;
      while (busy !== 1'b0 && n < 40) begin
        @(posedge clk); #1;
        n++;
      end
      if (n >= 40) chk("busy_stuck", gi, {31'b0, busy}, 32'd0);
    endtask

    task automatic issue(input logic w, input logic [1:0] s, input logic x,
                         input logic [31:0] a, input logic [31:0] d, input bit hold);
      exp_t ex;
      logic e;
      logic [31:0] r;
      wait_idle();
      req = 1'b1; we = w; sel = s; sx = x; addr = a; wdata = d;
      @(posedge clk);
      model(w, s, x, a, d, e, r);
      #1;
      ex.is_load = !w; ex.err = e; ex.rdata = r; ex.cyc = cyc;
      q.push_back(ex);
      acc_cyc = cyc;
      // Scramble inputs while busy: they must not affect the accepted request.
      we = 1'($urandom); sel = 2'($urandom); sx = 1'($urandom);
      addr = $urandom; wdata = $urandom; req = hold;
    endtask

    always @(negedge clk) begin
      exp_t e;
      if (rst_n !== 1'b1) begin
        run = 0;
      end else begin
        if (busy) run++;
        if (ack) begin
          acks++;
          chk("busy_during_ack", gi, {31'b0, busy}, 32'd0);
          if (q.size() == 0) begin
            chk("unexpected_ack", gi, 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            chk("err", gi, {31'b0, err}, {31'b0, e.err});
            if (e.is_load || e.err) chk("rdata", gi, rdata, e.rdata);
            chk("ack_latency", gi, 32'(cyc), 32'(e.cyc + LAT));
            chk("busy_length", gi, 32'(run), 32'(LAT));
          end
          run = 0;
        end else begin
          chk("quiet_rdata", gi, rdata, 32'd0);
          chk("quiet_err", gi, {31'b0, err}, 32'd0);
        end
      end
    end

    initial begin
      int a1, a2, a3, a0, g;
      bit hold, prev_hold;
      logic [31:0] ra;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", gi, {31'b0, busy}, 32'd0);
      chk("reset_ack", gi, {31'b0, ack}, 32'd0);
      chk("reset_err", gi, {31'b0, err}, 32'd0);
      chk("reset_rdata", gi, rdata, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      issue(1, W, 0, BASE + 32'h00, 32'h0BAD_F00D, 0);
      issue(1, W, 0, BASE + 32'h10, 32'hDEAD_BEEF, 0);
      issue(0, W, 0, BASE + 32'h10, 32'h0, 0);
      issue(1, B, 0, BASE + 32'h11, 32'hFFFF_FF55, 0);
      issue(0, W, 0, BASE + 32'h10, 32'h0, 0);
      issue(0, H, 1, BASE + 32'h12, 32'h0, 0);
      issue(0, H, 0, BASE + 32'h12, 32'h0, 0);
      issue(0, B, 1, BASE + 32'h10, 32'h0, 0);
      issue(0, W, 0, BASE + 32'h02, 32'h0, 0);
      issue(1, H, 0, BASE + 32'h01, 32'h1234_9999, 0);
      issue(0, W, 0, 32'h1000_FFFC, 32'h0, 0);
      issue(0, W, 0, BASE + LIMIT, 32'h0, 0);
      issue(0, W, 0, BASE + 32'h00, 32'h0, 0);
      issue(0, W, 0, BASE + 32'h10, 32'h0, 0);

      // Abort a store with a one-cycle reset pulse right after acceptance.
      issue(1, W, 0, BASE + 32'h20, 32'hCAFE_F00D, 0);
      wait_idle();
      req = 1'b1; we = 1'b1; sel = W; sx = 1'b0; addr = BASE + 32'h20; wdata = 32'h1234_5678;
      @(posedge clk); #1;
      req = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("abort_idle_busy", gi, {31'b0, busy}, 32'd0);
      a0 = acks;
      repeat (LAT + 3) @(posedge clk);
      #1;
      chk("abort_no_ack", gi, 32'(acks), 32'(a0));
      issue(0, W, 0, BASE + 32'h20, 32'h0, 0);

      // Back-to-back with req held high and addr scrambled while busy.
      issue(1, W, 0, BASE + 32'h30, 32'h7654_3210, 1); a1 = acc_cyc;
      issue(0, W, 0, BASE + 32'h30, 32'h0, 1);         a2 = acc_cyc;
      issue(0, B, 1, BASE + 32'h13, 32'h0, 1);         a3 = acc_cyc;
      req = 1'b0;
      chk("b2b_spacing_1", gi, 32'(a2 - a1), 32'(LAT + 1));
      chk("b2b_spacing_2", gi, 32'(a3 - a2), 32'(LAT + 1));

      // Seed the random region and the top word so every load hits known data.
      for (int i = 0; i < 16; i++) issue(1, W, 0, BASE + 32'(4 * i), $urandom, 0);
      issue(1, W, 0, BASE + LIMIT - 32'd4, $urandom, 0);

      prev_hold = 1'b0;
      for (int k = 0; k < 200; k++) begin
        case ($urandom_range(0, 9))
          0:       ra = BASE - 32'($urandom_range(1, 64));
          1:       ra = BASE + LIMIT + 32'($urandom_range(0, 64));
          2:       ra = BASE + LIMIT - 32'($urandom_range(1, 4));
          default: ra = BASE + 32'($urandom_range(0, 63));
        endcase
        if (!prev_hold) begin
          g = $urandom_range(0, 2);
          repeat (g) begin @(posedge clk); #1; end
        end
        hold = ($urandom_range(0, 3) == 0);
        issue(1'($urandom), 2'($urandom), 1'($urandom), ra, $urandom, hold);
        prev_hold = hold;
      end
      req = 1'b0;

      repeat (LAT + 4) @(posedge clk);
      #1;
      chk("queue_drained", gi, 32'(q.size()), 32'd0);
      fin = 1'b1;
    end
  end

  initial begin
    int n = 0;
    while (!(g_inst[0].fin && g_inst[1].fin && g_inst[2].fin && g_inst[3].fin) && n < 50000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 50000) chk("global_timeout", -1, 32'd0, 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
